// File: rtl/fmap_buf_pkg.sv
// Shared defaults and swap-FSM state encoding for the feature-map bank buffer.
package fmap_buf_pkg;
  localparam int NUM_BANKS_DEF = 8;
  localparam int DATA_W_DEF    = 16;
  localparam int DEPTH_DEF     = 12321;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_ACK   = 2'd2
  } swap_st_e;
endpackage

// File: rtl/bank_ram.sv
// One DATA_W x DEPTH simple dual-port bank; registered read, read-before-write.
module bank_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 12321,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // rdata only moves on re, so it holds between reads
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/fmap_bank_buffer.sv
// Multi-bank feature-map buffer with optional ping/pong halves, a drain-then-swap
// handshake and a sticky out-of-range error flag.
module fmap_bank_buffer
  import fmap_buf_pkg::*;
#(
  parameter int NUM_BANKS = NUM_BANKS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int PINGPONG  = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [NUM_BANKS*DATA_W-1:0] wr_data,
  input  logic [NUM_BANKS-1:0]        wr_mask,
  input  logic                        rd_en,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [NUM_BANKS*DATA_W-1:0] rd_data,
  output logic                        rd_valid,
  input  logic                        swap_req,
  output logic                        swap_ack,
  output logic                        wr_side,
  output logic                        err_oob,
  input  logic                        err_clr
);
  localparam int HALVES = (PINGPONG != 0) ? 2 : 1;

  logic wr_in, rd_in, rd_half, oob_hit;
  logic rd_half_q, rd_zero_q;
  logic [HALVES-1:0][NUM_BANKS-1:0][DATA_W-1:0] bank_q;
  swap_st_e state;

  // extra MSB keeps the compare correct when DEPTH is a power of two
  assign wr_in   = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
  assign rd_in   = ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH));
  assign rd_half = (PINGPONG != 0) ? ~wr_side : 1'b0;
  assign oob_hit = (wr_en && !wr_in) || (rd_en && !rd_in);

  for (genvar h = 0; h < HALVES; h++) begin : g_half
    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
      bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (wr_en && wr_in && wr_mask[k] && (wr_side == 1'(h))),
        .waddr (wr_addr),
        .wdata (wr_data[k*DATA_W +: DATA_W]),
        .re    (rd_en && rd_in && (rd_half == 1'(h))),
        .raddr (rd_addr),
        .rdata (bank_q[h][k])
      );
    end
  end

  // rd_zero_q covers both reset and out-of-range reads without touching the banks
  always_comb begin
    rd_data = '0;
    if (!rd_zero_q) rd_data = (HALVES > 1 && rd_half_q) ? bank_q[HALVES-1] : bank_q[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid  <= 1'b0;
      rd_half_q <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_half_q <= rd_half;
        rd_zero_q <= !rd_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_oob <= 1'b0;
    else if (oob_hit) err_oob <= 1'b1;
    else if (err_clr) err_oob <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_RUN;
      swap_ack <= 1'b0;
      wr_side  <= 1'b0;
    end else begin
      case (state)
        S_RUN: if (swap_req) state <= S_DRAIN;
        S_DRAIN: begin
          // halves flip only on an idle edge so no access straddles the swap
          if (!wr_en && !rd_en) begin
            state    <= S_ACK;
            swap_ack <= 1'b1;
            if (PINGPONG != 0) wr_side <= ~wr_side;
          end
        end
        S_ACK: begin
          swap_ack <= 1'b0;
          state    <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_fmap_bank_buffer.sv
// Directed + randomized check of fmap_bank_buffer against a half/address keyed memory model.
module tb_fmap_bank_buffer;
  localparam int NB = 8, DW = 16, DEPTH = 12321, AW = 14;

  logic clk = 1'b0, rst = 1'b0;
  logic wr_en = 1'b0, rd_en = 1'b0, swap_req = 1'b0, err_clr = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [NB*DW-1:0] wr_data = '0;
  logic [NB-1:0] wr_mask = '0;
  logic [NB*DW-1:0] rd_data;
  logic rd_valid, swap_ack, wr_side, err_oob;

  int ncmp = 0, nerr = 0;

  logic [NB*DW-1:0] mem [int];
  logic [NB*DW-1:0] m_data;
  logic m_valid, m_side, m_err, m_ack, m_pend;
  int pool [8] = '{0, 1, 2, 5, 7, 100, 12320, 3000};

  fmap_bank_buffer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .swap_req(swap_req), .swap_ack(swap_ack),
    .wr_side(wr_side), .err_oob(err_oob), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_data = '0; m_valid = 1'b0; m_side = 1'b0;
    m_err = 1'b0; m_ack = 1'b0; m_pend = 1'b0;
  endfunction

  // one clock edge of the behaviour: read old contents, then write, then swap progress
  function automatic void model_update();
    int key;
    logic [NB*DW-1:0] w;
    if (rd_en) begin
      m_valid = 1'b1;
      if (int'(rd_addr) >= DEPTH) m_data = '0;
      else m_data = mem[(m_side ? 0 : 1) * 16384 + int'(rd_addr)];
    end else m_valid = 1'b0;
    if (wr_en && int'(wr_addr) < DEPTH) begin
      key = (m_side ? 1 : 0) * 16384 + int'(wr_addr);
      w = mem.exists(key) ? mem[key] : 'x;
      for (int k = 0; k < NB; k++) if (wr_mask[k]) w[k*DW +: DW] = wr_data[k*DW +: DW];
      mem[key] = w;
    end
    if ((wr_en && int'(wr_addr) >= DEPTH) || (rd_en && int'(rd_addr) >= DEPTH)) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    if (m_ack) m_ack = 1'b0;
    else if (!m_pend) m_pend = swap_req;
    else if (!wr_en && !rd_en) begin
      m_pend = 1'b0; m_ack = 1'b1; m_side = !m_side;
    end
  endfunction

  task automatic chk(input string tag, input logic [NB*DW-1:0] obs, input logic [NB*DW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/rd_valid"}, {127'd0, rd_valid}, {127'd0, m_valid});
    chk({tag, "/rd_data"}, rd_data, m_data);
    chk({tag, "/wr_side"}, {127'd0, wr_side}, {127'd0, m_side});
    chk({tag, "/err_oob"}, {127'd0, err_oob}, {127'd0, m_err});
    chk({tag, "/swap_ack"}, {127'd0, swap_ack}, {127'd0, m_ack});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) model_reset();
    else model_update();
    #1;
    check_all(tag);
  endtask

  task automatic do_write(input int a, input logic [NB*DW-1:0] d, input logic [NB-1:0] m);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_mask = m;
    step("write");
    wr_en = 1'b0;
  endtask

  task automatic do_read(input int a);
    rd_en = 1'b1; rd_addr = AW'(a);
    step("read");
    rd_en = 1'b0;
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    for (int i = 0; i < 20 && swap_req; i++) begin
      step("swap");
      if (m_ack) swap_req = 1'b0;
    end
    if (swap_req) begin
      ncmp++; nerr++;
      $error("FAIL swap_timeout: observed no swap_ack expected one within 20 cycles");
      swap_req = 1'b0;
    end
  endtask

  task automatic req031(input string tag);
    logic [NB*DW-1:0] d;
    for (int k = 0; k < NB; k++) d[k*DW +: DW] = DW'(k + 1);
    do_write(5, d, 8'hFF);
    do_swap();
    do_read(5);
    chk({tag, "/data"}, rd_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk({tag, "/valid"}, {127'd0, rd_valid}, 128'd1);
  endtask

  initial begin
    logic old_side;
    model_reset();
    step("reset"); step("reset");
    chk("reset/rd_data_zero", rd_data, '0);
    rst = 1'b1;
    step("idle");

    req031("req031");

    do_write(7, {8{16'hAAAA}}, 8'hFF);
    do_write(7, {8{16'h5555}}, 8'h0F);
    do_swap();
    do_read(7);
    chk("req032/data", rd_data, 128'hAAAA_AAAA_AAAA_AAAA_5555_5555_5555_5555);

    do_write(DEPTH, {8{16'hFFFF}}, 8'hFF);
    chk("req033/err_set", {127'd0, err_oob}, 128'd1);
    do_read(DEPTH);
    chk("req033/oob_zero", rd_data, '0);
    chk("req033/oob_valid", {127'd0, rd_valid}, 128'd1);
    rd_en = 1'b1; rd_addr = AW'(DEPTH); err_clr = 1'b1;
    step("err_clr_collide");
    rd_en = 1'b0;
    step("err_clr");
    err_clr = 1'b0;
    chk("req033/err_cleared", {127'd0, err_oob}, 128'd0);
    step("idle");

    // fill every pool address in both halves with full-mask data
    for (int p = 0; p < 2; p++) begin
      foreach (pool[i]) do_write(pool[i], {$urandom, $urandom, $urandom, $urandom}, 8'hFF);
      do_swap();
    end

    // swap requested, then three back-to-back reads hold it in drain
    old_side = m_side;
    swap_req = 1'b1;
    step("req034_req");
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; rd_addr = AW'(pool[i]);
      step("req034_drain_read");
      chk("req034/no_early_toggle", {127'd0, wr_side}, {127'd0, old_side});
    end
    rd_en = 1'b0;
    step("req034_swap");
    swap_req = 1'b0;
    chk("req034/ack", {127'd0, swap_ack}, 128'd1);
    chk("req034/toggled", {127'd0, wr_side}, {127'd0, !old_side});
    step("req034_ack_drop");

    for (int c = 0; c < 400; c++) begin
      wr_en = ($urandom_range(0, 1) == 1);
      rd_en = ($urandom_range(0, 1) == 1);
      wr_addr = ($urandom_range(0, 15) == 0) ? AW'(DEPTH + $urandom_range(0, 4000))
                                             : AW'(pool[$urandom_range(0, 7)]);
      rd_addr = ($urandom_range(0, 15) == 0) ? AW'(DEPTH + $urandom_range(0, 4000))
                                             : AW'(pool[$urandom_range(0, 7)]);
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      wr_mask = NB'($urandom);
      err_clr = ($urandom_range(0, 7) == 0);
      step("random");
      if (m_ack) swap_req = 1'b0;
      else if (!swap_req && $urandom_range(0, 19) == 0) swap_req = 1'b1;
    end
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 10 && swap_req; i++) begin
      step("random_flush");
      if (m_ack) swap_req = 1'b0;
    end
    swap_req = 1'b0;
    step("idle");
    if (!m_side) do_swap();
    step("idle");

    // reset lands while draining and with a read in flight
    swap_req = 1'b1;
    step("rst_drain");
    rd_en = 1'b1; rd_addr = AW'(pool[3]);
    @(posedge clk);
    model_update();
    #2 rst = 1'b0;
    model_reset();
    #1 check_all("rst_async");
    chk("req035/rd_valid", {127'd0, rd_valid}, 128'd0);
    chk("req035/wr_side", {127'd0, wr_side}, 128'd0);
    rd_en = 1'b0;
    step("rst_hold"); step("rst_hold");
    rst = 1'b1; swap_req = 1'b0;
    step("rst_release"); step("rst_release");
    chk("req035/no_ack", {127'd0, swap_ack}, 128'd0);
    req031("req035_rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/fmap_bank_buffer.md
FMAP_BANK_BUFFER -- requirements
Module: fmap_bank_buffer

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 8, number of parallel 16-bit channel banks.
REQ-002 SHALL have parameter DATA_W, default 16, word width per bank.
REQ-003 SHALL have parameter DEPTH, default 12321 (111*111), words per bank per half.
REQ-004 SHALL have parameter PINGPONG, default 1, 1 = two halves (ping/pong), 0 = single half.
REQ-005 SHALL derive localparam ADDR_W = $clog2(DEPTH), 14 at defaults.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 wr_en  in  1  write strobe; wr_addr  in  ADDR_W  write address.
REQ-009 wr_data  in  NUM_BANKS*DATA_W  bank k in bits [k*DATA_W +: DATA_W]; wr_mask  in  NUM_BANKS  per-bank write enable.
REQ-010 rd_en  in  1  read strobe; rd_addr  in  ADDR_W  read address.
REQ-011 rd_data  out  NUM_BANKS*DATA_W  registered read data, same packing; rd_valid  out  1  rd_data qualifier.
REQ-012 swap_req  in  1  level request to exchange halves, held until swap_ack; swap_ack  out  1  one-cycle pulse.
REQ-013 wr_side  out  1  half currently written (reader uses the other); err_oob  out  1  sticky out-of-range flag; err_clr  in  1  clears err_oob.

Function
REQ-014 Write: wr_en=1 and wr_addr<DEPTH SHALL store wr_data lane k into bank k of half wr_side at wr_addr for every k with wr_mask[k]=1; unmasked banks unchanged.
REQ-015 Read: rd_en=1 SHALL present all NUM_BANKS words of half ~wr_side (half 0 when PINGPONG=0) at rd_addr on rd_data with rd_valid=1 exactly one cycle later.
REQ-016 rd_en=0 SHALL deassert rd_valid next cycle; rd_data SHALL hold its last value.
REQ-017 Address >= DEPTH: write SHALL be dropped; read SHALL return all-zero rd_data with rd_valid=1; either SHALL set err_oob next cycle.
REQ-018 err_oob SHALL stay set until err_clr=1; simultaneous new error and err_clr SHALL leave err_oob=1.
REQ-019 PINGPONG=0, read and write to same address same cycle: read SHALL return the old (pre-write) data.
REQ-020 Swap FSM states RUN, DRAIN, ACK; RUN->DRAIN when swap_req=1.
REQ-021 DRAIN: accesses continue normally; DRAIN->ACK on the first cycle with wr_en=0 and rd_en=0, toggling wr_side at that edge (PINGPONG=1 only).
REQ-022 ACK: swap_ack=1 for exactly one cycle, then ->RUN; swap_req still high in RUN re-requests.
REQ-023 PINGPONG=0: swap sequence SHALL run identically but wr_side SHALL remain 0.
REQ-024 Access in the cycle the swap edge occurs SHALL not exist (REQ-021); an access issued the cycle after SHALL use the new wr_side.

Reset
REQ-025 rst=0 SHALL asynchronously force rd_data=0, rd_valid=0, swap_ack=0, wr_side=0, err_oob=0, FSM=RUN.
REQ-026 Memory contents SHALL not be reset; reset mid-read SHALL drop the pending rd_valid.
REQ-027 Reset mid-swap SHALL abort it with no swap_ack and wr_side=0.

Structure
REQ-028 Package fmap_buf_pkg SHALL hold default NUM_BANKS, DATA_W, DEPTH and the swap-FSM state enum.
REQ-029 Sub-module bank_ram SHALL implement one DATA_W x DEPTH simple dual-port bank, registered read-before-write; instantiated NUM_BANKS*(PINGPONG+1) times.
REQ-030 Out-of-range detection, masking, half selection and FSM SHALL live in fmap_bank_buffer.

Verification
REQ-031 Write addr 5, data lanes 0x0001..0x0008, mask 0xFF; swap; read addr 5 -> next cycle rd_data lanes 0x0001..0x0008, rd_valid=1.
REQ-032 Write addr 7 all 0xAAAA, then addr 7 all 0x5555 mask 0x0F; swap; read 7 -> lanes 0-3 0x5555, lanes 4-7 0xAAAA.
REQ-033 Write addr 12321 -> err_oob=1 next cycle, no bank changed; read 12321 -> rd_data=0, rd_valid=1; err_clr -> err_oob=0.
REQ-034 swap_req with rd_en high 3 cycles -> DRAIN held 3 cycles, wr_side toggles after, swap_ack single pulse, all 3 reads valid from old half.
REQ-035 rst low during DRAIN and during a read -> rd_valid=0, swap_ack never pulses, wr_side=0; rerun REQ-031 after rst release passes.
